// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch-flush and memory-wait hazard control for an in-order pipe.
// Latency: control outputs are combinational from state and inputs; state, counters and timeout are registered.
// Backpressure: mem_busy_i holds the whole pipe; timeout_o is sticky after WAIT_MAX busy cycles.
// Optional feature macro PIPE_HAZARD_CTRL_PERF_EN: saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MWAIT   = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    // First load-stall cycle happens in RUN, so LDSTALL covers the remaining LOAD_LAT-1 cycles.
    localparam logic [3:0]  LD_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_ld_cnt;
    logic [3:0]  w_ld_cnt_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;

    logic        w_hazard;
    logic        w_run_eval;
    logic        w_pc_write;
    logic        w_stall;
    logic        w_flush;
    logic        w_bubble;
    logic        w_hold;

    // Load-use hazard: x0 is never a real dependency.
    assign w_hazard = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

    // Next-state and control decode; MWAIT with memory ready behaves exactly like RUN.
    always_comb begin
        w_pc_write     = 1'b0;
        w_stall        = 1'b0;
        w_flush        = 1'b0;
        w_bubble       = 1'b0;
        w_hold         = 1'b0;
        w_run_eval     = 1'b0;
        w_state_nxt    = r_state;
        w_ld_cnt_nxt   = r_ld_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;

        case (r_state)
            ST_RUN: begin
                w_run_eval = 1'b1;
            end
            ST_LDSTALL: begin
                if (mem_busy_i) begin
                    // Memory wait wins; remaining load stall is dropped and the hazard re-detected later.
                    w_stall        = 1'b1;
                    w_hold         = 1'b1;
                    w_state_nxt    = ST_MWAIT;
                    w_ld_cnt_nxt   = 4'd0;
                    w_wait_cnt_nxt = 16'd1;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_ld_cnt <= 4'd1) begin
                        w_ld_cnt_nxt = 4'd0;
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_ld_cnt_nxt = r_ld_cnt - 4'd1;
                    end
                end
            end
            ST_MWAIT: begin
                if (mem_busy_i) begin
                    w_stall        = 1'b1;
                    w_hold         = 1'b1;
                    w_wait_cnt_nxt = (r_wait_cnt >= WAIT_LIM) ? r_wait_cnt : (r_wait_cnt + 16'd1);
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: hold the front end for one cycle and recover to RUN.
                w_stall        = 1'b1;
                w_state_nxt    = ST_RUN;
                w_ld_cnt_nxt   = 4'd0;
                w_wait_cnt_nxt = 16'd0;
            end
        endcase

        if (w_run_eval) begin
            w_ld_cnt_nxt   = 4'd0;
            w_wait_cnt_nxt = 16'd0;
            w_state_nxt    = ST_RUN;
            if (mem_busy_i) begin
                w_stall        = 1'b1;
                w_hold         = 1'b1;
                w_wait_cnt_nxt = 16'd1;
                w_state_nxt    = ST_MWAIT;
            end else if (w_hazard) begin
                // A same-cycle branch is ignored here; it is re-presented after the stall.
                w_stall      = 1'b1;
                w_bubble     = 1'b1;
                w_ld_cnt_nxt = LD_INIT;
                w_state_nxt  = (LOAD_LAT > 1) ? ST_LDSTALL : ST_RUN;
            end else if (branch_taken_i) begin
                w_pc_write = 1'b1;
                w_flush    = 1'b1;
            end else begin
                w_pc_write = 1'b1;
            end
        end

        if (w_hold && (w_wait_cnt_nxt >= WAIT_LIM)) begin
            w_timeout_nxt = 1'b1;
        end
    end

    // Controller state, wait/load counters and sticky timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_ld_cnt   <= 4'd0;
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ld_cnt   <= w_ld_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Reset forces a flush with the PC frozen, independent of the clock.
    assign pc_write_o    = rst_i ? 1'b0 : w_pc_write;
    assign ifid_stall_o  = rst_i ? 1'b0 : w_stall;
    assign ifid_flush_o  = rst_i ? 1'b1 : w_flush;
    assign idex_bubble_o = rst_i ? 1'b0 : w_bubble;
    assign pipe_hold_o   = rst_i ? 1'b0 : w_hold;
    assign state_o       = r_state;
    assign timeout_o     = r_timeout;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of stall and flush cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ifid_stall_o && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_flush_o && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with LOAD_LAT=1, one with LOAD_LAT=3, shared stimulus.
// Control outputs packed as {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_hold, state[1:0]}.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later, well before the next edge.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       memrd;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic       busy;

    logic        a_pcw, a_stl, a_fl, a_bub, a_hold, a_to;
    logic [1:0]  a_state;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_pcw, b_stl, b_fl, b_bub, b_hold, b_to;
    logic [1:0]  b_state;
    logic [31:0] b_scnt, b_fcnt;

    wire [6:0] a_ctl = {a_pcw, a_stl, a_fl, a_bub, a_hold, a_state};
    wire [6:0] b_ctl = {b_pcw, b_stl, b_fl, b_bub, b_hold, b_state};

    localparam logic [6:0] C_RESET   = 7'b0010000;
    localparam logic [6:0] C_IDLE    = 7'b1000000;
    localparam logic [6:0] C_BRANCH  = 7'b1010000;
    localparam logic [6:0] C_HAZ     = 7'b0101000;
    localparam logic [6:0] C_LDSTALL = 7'b0101001;
    localparam logic [6:0] C_BUSY0   = 7'b0100100;
    localparam logic [6:0] C_BUSY1   = 7'b0100101;
    localparam logic [6:0] C_BUSYW   = 7'b0100110;
    localparam logic [6:0] C_WREL    = 7'b1000010;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam logic [31:0] EXP_SCNT = 32'd2;
    localparam logic [31:0] EXP_FCNT = 32'd1;
`else
    localparam logic [31:0] EXP_SCNT = 32'd0;
    localparam logic [31:0] EXP_FCNT = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .WAIT_MAX(255), .CNT_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memrd), .idex_rd_i(rd),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .branch_taken_i(br), .mem_busy_i(busy),
        .pc_write_o(a_pcw), .ifid_stall_o(a_stl), .ifid_flush_o(a_fl),
        .idex_bubble_o(a_bub), .pipe_hold_o(a_hold), .state_o(a_state),
        .timeout_o(a_to), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .WAIT_MAX(255), .CNT_W(32)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .idex_memread_i(memrd), .idex_rd_i(rd),
        .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .branch_taken_i(br), .mem_busy_i(busy),
        .pc_write_o(b_pcw), .ifid_stall_o(b_stl), .ifid_flush_o(b_fl),
        .idex_bubble_o(b_bub), .pipe_hold_o(b_hold), .state_o(b_state),
        .timeout_o(b_to), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        memrd = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; br = 1'b0; busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        #23;
        checks++; if (a_ctl !== C_RESET) begin errors++; $display("FAIL rst_ctl_a got %b exp %b", a_ctl, C_RESET); end
        checks++; if (b_ctl !== C_RESET) begin errors++; $display("FAIL rst_ctl_b got %b exp %b", b_ctl, C_RESET); end
        checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", a_to); end
        checks++; if ({a_scnt, a_fcnt} !== 64'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", a_scnt, a_fcnt); end
        cyc();
        rst = 1'b0;
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL post_rst_idle got %b exp %b", a_ctl, C_IDLE); end
    endtask

    task automatic test_load_use();
        cyc();
        memrd = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
        #2;
        checks++; if (a_ctl !== C_HAZ) begin errors++; $display("FAIL lu_a_c0 got %b exp %b", a_ctl, C_HAZ); end
        checks++; if (b_ctl !== C_HAZ) begin errors++; $display("FAIL lu_b_c0 got %b exp %b", b_ctl, C_HAZ); end
        cyc();
        clear_in();
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL lu_a_c1 got %b exp %b", a_ctl, C_IDLE); end
        checks++; if (b_ctl !== C_LDSTALL) begin errors++; $display("FAIL lu_b_c1 got %b exp %b", b_ctl, C_LDSTALL); end
        cyc();
        #2;
        checks++; if (b_ctl !== C_LDSTALL) begin errors++; $display("FAIL lu_b_c2 got %b exp %b", b_ctl, C_LDSTALL); end
        cyc();
        #2;
        checks++; if (b_ctl !== C_IDLE) begin errors++; $display("FAIL lu_b_c3 got %b exp %b", b_ctl, C_IDLE); end
        // rs1 match also counts; a non-matching load and a matching non-load do not.
        cyc();
        memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd1;
        #2;
        checks++; if (a_ctl !== C_HAZ) begin errors++; $display("FAIL lu_rs1 got %b exp %b", a_ctl, C_HAZ); end
        cyc();
        memrd = 1'b1; rd = 5'd7; rs1 = 5'd6; rs2 = 5'd8;
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL lu_nomatch got %b exp %b", a_ctl, C_IDLE); end
        cyc();
        memrd = 1'b0; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL lu_noload got %b exp %b", a_ctl, C_IDLE); end
        cyc();
        clear_in();
    endtask

    task automatic test_x0_branch();
        cyc();
        memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL x0_nostall got %b exp %b", a_ctl, C_IDLE); end
        cyc();
        clear_in();
        br = 1'b1;
        #2;
        checks++; if (a_ctl !== C_BRANCH) begin errors++; $display("FAIL branch got %b exp %b", a_ctl, C_BRANCH); end
        cyc();
        br = 1'b0;
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL branch_after got %b exp %b", a_ctl, C_IDLE); end
    endtask

    task automatic test_hazard_branch();
        cyc();
        memrd = 1'b1; rd = 5'd4; rs1 = 5'd4; rs2 = 5'd2; br = 1'b1;
        #2;
        checks++; if (a_ctl !== C_HAZ) begin errors++; $display("FAIL hzbr_stall got %b exp %b", a_ctl, C_HAZ); end
        cyc();
        memrd = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #2;
        checks++; if (a_ctl !== C_BRANCH) begin errors++; $display("FAIL hzbr_flush got %b exp %b", a_ctl, C_BRANCH); end
        cyc();
        clear_in();
        // Let instance B finish its longer load stall.
        cyc();
        cyc();
    endtask

    task automatic test_busy_short();
        cyc();
        busy = 1'b1; memrd = 1'b1; rd = 5'd3; rs1 = 5'd3; br = 1'b1;
        #2;
        checks++; if (a_ctl !== C_BUSY0) begin errors++; $display("FAIL busy_c1 got %b exp %b", a_ctl, C_BUSY0); end
        for (int i = 2; i <= 4; i++) begin
            cyc();
            memrd = 1'b0; rd = 5'd0; rs1 = 5'd0; br = 1'b0;
            #2;
            checks++; if (a_ctl !== C_BUSYW) begin errors++; $display("FAIL busy_c%0d got %b exp %b", i, a_ctl, C_BUSYW); end
        end
        cyc();
        busy = 1'b0;
        #2;
        checks++; if (a_ctl !== C_WREL) begin errors++; $display("FAIL busy_rel got %b exp %b", a_ctl, C_WREL); end
        checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL busy_short_to got %b exp 0", a_to); end
        cyc();
        #2;
        checks++; if (a_ctl !== C_IDLE) begin errors++; $display("FAIL busy_back_run got %b exp %b", a_ctl, C_IDLE); end
    endtask

    task automatic test_ldstall_busy();
        cyc();
        memrd = 1'b1; rd = 5'd6; rs2 = 5'd6;
        cyc();
        clear_in();
        busy = 1'b1;
        #2;
        checks++; if (b_ctl !== C_BUSY1) begin errors++; $display("FAIL ldb_busy got %b exp %b", b_ctl, C_BUSY1); end
        cyc();
        #2;
        checks++; if (b_ctl !== C_BUSYW) begin errors++; $display("FAIL ldb_wait got %b exp %b", b_ctl, C_BUSYW); end
        cyc();
        busy = 1'b0;
        #2;
        checks++; if (b_ctl !== C_WREL) begin errors++; $display("FAIL ldb_rel got %b exp %b", b_ctl, C_WREL); end
        cyc();
        #2;
        checks++; if (b_ctl !== C_IDLE) begin errors++; $display("FAIL ldb_discard got %b exp %b", b_ctl, C_IDLE); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 300; i++) begin
            cyc();
            busy = 1'b1;
            #2;
            if (i == 255) begin
                checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL to_before got %b exp 0", a_to); end
            end
            if (i == 256) begin
                checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", a_to); end
            end
            if (i == 300) begin
                checks++; if (a_ctl !== C_BUSYW) begin errors++; $display("FAIL to_hold got %b exp %b", a_ctl, C_BUSYW); end
            end
        end
        cyc();
        busy = 1'b0;
        #2;
        checks++; if (a_ctl !== C_WREL) begin errors++; $display("FAIL to_rel got %b exp %b", a_ctl, C_WREL); end
        cyc();
        cyc();
        #2;
        checks++; if (a_to !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", a_to); end
    endtask

    task automatic test_async_reset();
        cyc();
        memrd = 1'b1; rd = 5'd8; rs1 = 5'd8;
        cyc();
        clear_in();
        #2;
        checks++; if (b_ctl !== C_LDSTALL) begin errors++; $display("FAIL ar_pre got %b exp %b", b_ctl, C_LDSTALL); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (b_ctl !== C_RESET) begin errors++; $display("FAIL ar_state got %b exp %b", b_ctl, C_RESET); end
        checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL ar_timeout got %b exp 0", a_to); end
        checks++; if ({a_scnt, a_fcnt} !== 64'd0) begin errors++; $display("FAIL ar_cnt got %0d/%0d exp 0/0", a_scnt, a_fcnt); end
        cyc();
        cyc();
        rst = 1'b0;
        #2;
        checks++; if (b_ctl !== C_IDLE) begin errors++; $display("FAIL ar_release got %b exp %b", b_ctl, C_IDLE); end
    endtask

    task automatic test_perf();
        cyc();
        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5;
        cyc();
        clear_in();
        cyc();
        memrd = 1'b1; rd = 5'd2; rs1 = 5'd2;
        cyc();
        clear_in();
        cyc();
        br = 1'b1;
        cyc();
        br = 1'b0;
        cyc();
        #2;
        checks++; if (a_scnt !== EXP_SCNT) begin errors++; $display("FAIL perf_stall got %0d exp %0d", a_scnt, EXP_SCNT); end
        checks++; if (a_fcnt !== EXP_FCNT) begin errors++; $display("FAIL perf_flush got %0d exp %0d", a_fcnt, EXP_FCNT); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_branch();
        test_hazard_branch();
        test_busy_short();
        test_ldstall_busy();
        test_timeout();
        test_async_reset();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
